chip8_scanout: RTL and testbench

- Display-side consumer of the chip-8 video core's pixel request interface.
- Walks a 1280x720 raster timing stream and issues pixel_x/pixel_y requests for the 64x32 chip-8 image, scaled by 2^SCALE_LOG2 and centred.
- Takes back the 1-bit pixel value, maps it to 24-bit RGB, and forwards sync/active aligned to the colour.
- Emits the once-per-frame buffer-swap pulse that drives the video core's ad_in.

---
 rtl/chip8_pkg.sv | 33 +++
 rtl/chip8_delay.sv | 39 +++
 rtl/chip8_scanout.sv | 226 ++++++++++++++++++++++
 tb/tb_chip8_scanout.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared definitions for the chip-8 display path.
//   CHIP8_W / CHIP8_H   : native chip-8 framebuffer size in pixels
//   H_ACTIVE            : visible raster width of the 1280x720 timing stream
//   V_ACTIVE_DEFAULT    : visible raster height (first blanking row)
//   rgb_t               : 24-bit colour, 8 bits per channel
//   rgb_dim()           : halves every channel of a colour (scanline shading)
// No ports (package).
// -----------------------------------------------------------------------------
package chip8_pkg;

    localparam int CHIP8_W          = 64;
    localparam int CHIP8_H          = 32;
    localparam int H_ACTIVE         = 1280;
    localparam int V_ACTIVE_DEFAULT = 720;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Halve each channel independently so no bit leaks between channels.
    function automatic rgb_t rgb_dim(input rgb_t c);
        rgb_t d;
        d.r = {1'b0, c.r[7:1]};
        d.g = {1'b0, c.g[7:1]};
        d.b = {1'b0, c.b[7:1]};
        return d;
    endfunction

endpackage

// File: rtl/chip8_delay.sv
// -----------------------------------------------------------------------------
// chip8_delay
// WIDTH-bit wide, DEPTH-stage register shift line with synchronous reset.
// data_out is data_in delayed by exactly DEPTH clock cycles (DEPTH >= 1).
// Ports:
//   clk_in   : clock
//   rst_in   : synchronous active-high reset, clears every stage
//   data_in  : word entering the line
//   data_out : word leaving the last stage
// -----------------------------------------------------------------------------
module chip8_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the line by one stage each cycle; reset flushes every stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign data_out = stage_r[DEPTH-1];

endmodule

// File: rtl/chip8_scanout.sv
// -----------------------------------------------------------------------------
// chip8_scanout
// Display-side consumer of the chip-8 video core pixel request interface.
// Walks the 1280x720 raster, requests the 64x32 chip-8 pixel that covers the
// current raster position (image scaled by 2^SCALE_LOG2 and placed at
// H_OFFSET/V_OFFSET), turns the returned bit into RGB, and re-aligns the
// sync/active strobes with the colour. Also generates the once-per-frame
// buffer-swap pulse for the video core.
//
// Optional build macro: CHIP8_SCANLINE_EN
//   When defined, the last sub-row of every scaled chip-8 row is drawn at half
//   brightness (each channel shifted right by one). Border/blanking unchanged.
//
// Ports:
//   clk_in, rst_in       : clock, synchronous active-high reset
//   hcount_in/vcount_in  : raster column / row
//   active_in, hsync_in, vsync_in : raster strobes
//   light/dark/border_color_in    : palette, sampled live at the colour stage
//   pixel_in             : pixel bit returned READ_LATENCY cycles after request
//   pixel_x_out/pixel_y_out       : chip-8 pixel request (0 outside the window)
//   rgb_out, active_out, hsync_out, vsync_out : aligned video out
//                          (READ_LATENCY+2 cycles after the raster input)
//   frame_swap_out       : one-cycle pulse after (hcount 0, vcount V_ACTIVE)
// -----------------------------------------------------------------------------
module chip8_scanout
    import chip8_pkg::*;
#(
    parameter int SCALE_LOG2   = 4,
    parameter int H_OFFSET     = 128,
    parameter int V_OFFSET     = 104,
    parameter int V_ACTIVE     = V_ACTIVE_DEFAULT,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] light_color_in,
    input  logic [23:0] dark_color_in,
    input  logic [23:0] border_color_in,
    input  logic        pixel_in,
    output logic [5:0]  pixel_x_out,
    output logic [4:0]  pixel_y_out,
    output logic [23:0] rgb_out,
    output logic        active_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_swap_out
);

    // Window bounds, one bit wider than the counters so the end column/row
    // cannot wrap.
    localparam logic [11:0] H_START_C = 12'(H_OFFSET);
    localparam logic [11:0] H_END_C   = 12'(H_OFFSET + (CHIP8_W << SCALE_LOG2));
    localparam logic [10:0] V_START_C = 11'(V_OFFSET);
    localparam logic [10:0] V_END_C   = 11'(V_OFFSET + (CHIP8_H << SCALE_LOG2));
    localparam logic [10:0] H_OFF_C   = 11'(H_OFFSET);
    localparam logic [9:0]  V_OFF_C   = 10'(V_OFFSET);
    localparam logic [9:0]  V_SWAP_C  = 10'(V_ACTIVE);

    // ---------------- stage 1: window test and pixel request ----------------
    logic [10:0] x_rel_s;
    logic [9:0]  y_rel_s;
    logic [10:0] x_shift_s;
    logic [9:0]  y_shift_s;
    logic        in_window_s;
    logic        swap_s;
    logic [5:0]  px_next_s;
    logic [4:0]  py_next_s;

    logic        in_window_r;
    logic        active_r;
    logic        hsync_r;
    logic        vsync_r;

    assign x_rel_s   = hcount_in - H_OFF_C;
    assign y_rel_s   = vcount_in - V_OFF_C;
    assign x_shift_s = x_rel_s >> SCALE_LOG2;
    assign y_shift_s = y_rel_s >> SCALE_LOG2;

    assign in_window_s = ({1'b0, hcount_in} >= H_START_C) &&
                         ({1'b0, hcount_in} <  H_END_C)   &&
                         ({1'b0, vcount_in} >= V_START_C) &&
                         ({1'b0, vcount_in} <  V_END_C);

    assign swap_s = (hcount_in == 11'd0) && (vcount_in == V_SWAP_C);

    // Upper quotient bits are always zero inside the window; they are dropped.
    logic unused_quot_s;
    assign unused_quot_s = ^{x_shift_s[10:6], y_shift_s[9:5]};

    // Request coordinates; anything outside the window asks for pixel (0,0).
    always_comb begin
        px_next_s = 6'd0;
        py_next_s = 5'd0;
        if (in_window_s) begin
            px_next_s = x_shift_s[5:0];
            py_next_s = y_shift_s[4:0];
        end else begin
            px_next_s = 6'd0;
            py_next_s = 5'd0;
        end
    end

`ifdef CHIP8_SCANLINE_EN
    logic subrow_s;
    logic subrow_r;
    assign subrow_s = &y_rel_s[SCALE_LOG2-1:0];

    // Sub-row flag register, aligned with the stage-1 request.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            subrow_r <= 1'b0;
        end else begin
            subrow_r <= subrow_s;
        end
    end
`endif

    // Stage-1 register: request outputs, swap pulse and strobes for the line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_x_out    <= 6'd0;
            pixel_y_out    <= 5'd0;
            frame_swap_out <= 1'b0;
            in_window_r    <= 1'b0;
            active_r       <= 1'b0;
            hsync_r        <= 1'b0;
            vsync_r        <= 1'b0;
        end else begin
            pixel_x_out    <= px_next_s;
            pixel_y_out    <= py_next_s;
            frame_swap_out <= swap_s;
            in_window_r    <= in_window_s;
            active_r       <= active_in;
            hsync_r        <= hsync_in;
            vsync_r        <= vsync_in;
        end
    end

    // ---------------- delay line: wait for the pixel read ----------------
`ifdef CHIP8_SCANLINE_EN
    localparam int DLY_W = 5;
`else
    localparam int DLY_W = 4;
`endif

    logic [DLY_W-1:0] dly_in_s;
    logic [DLY_W-1:0] dly_out_s;
    logic             dly_in_window_s;
    logic             dly_active_s;
    logic             dly_hsync_s;
    logic             dly_vsync_s;

`ifdef CHIP8_SCANLINE_EN
    logic dly_subrow_s;
    assign dly_in_s     = {subrow_r, in_window_r, active_r, hsync_r, vsync_r};
    assign dly_subrow_s = dly_out_s[4];
`else
    assign dly_in_s     = {in_window_r, active_r, hsync_r, vsync_r};
`endif

    assign dly_in_window_s = dly_out_s[3];
    assign dly_active_s    = dly_out_s[2];
    assign dly_hsync_s     = dly_out_s[1];
    assign dly_vsync_s     = dly_out_s[0];

    chip8_delay #(
        .WIDTH (DLY_W),
        .DEPTH (READ_LATENCY)
    ) u_delay (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  (dly_in_s),
        .data_out (dly_out_s)
    );

    // ---------------- colour stage ----------------
    rgb_t pick_s;
    rgb_t rgb_next_s;

    // Palette lookup: blanking is black, off-window is border, else lit/dark.
    always_comb begin
        pick_s = 24'h000000;
        if (!dly_active_s) begin
            pick_s = 24'h000000;
        end else if (!dly_in_window_s) begin
            pick_s = border_color_in;
        end else if (pixel_in) begin
            pick_s = light_color_in;
        end else begin
            pick_s = dark_color_in;
        end
    end

    // Optional scanline shading, only on lit/dark pixels inside the window.
    always_comb begin
        rgb_next_s = pick_s;
`ifdef CHIP8_SCANLINE_EN
        if (dly_active_s && dly_in_window_s && dly_subrow_s) begin
            rgb_next_s = rgb_dim(pick_s);
        end else begin
            rgb_next_s = pick_s;
        end
`endif
    end

    // Output register: colour and the strobes that belong to it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rgb_out    <= 24'h000000;
            active_out <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
        end else begin
            rgb_out    <= rgb_next_s;
            active_out <= dly_active_s;
            hsync_out  <= dly_hsync_s;
            vsync_out  <= dly_vsync_s;
        end
    end

endmodule

// File: tb/tb_chip8_scanout.sv
// -----------------------------------------------------------------------------
// tb_chip8_scanout
// Self-checking bench for chip8_scanout. A small video-core model answers the
// pixel requests from a fixed checkerboard image; expected outputs are pushed
// to scoreboard queues with the cycle they are due and compared on the
// falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_chip8_scanout;

    localparam int RL = 1;
`ifdef CHIP8_SCANLINE_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    localparam int CAT_BLACK  = 0;
    localparam int CAT_BORDER = 1;
    localparam int CAT_DARK   = 2;
    localparam int CAT_LIT    = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        active_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [23:0] light_color_in;
    logic [23:0] dark_color_in;
    logic [23:0] border_color_in;
    logic        pixel_in;
    logic [5:0]  pixel_x_out;
    logic [4:0]  pixel_y_out;
    logic [23:0] rgb_out;
    logic        active_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_swap_out;

    always #5 clk_in = ~clk_in;

    chip8_scanout #(
        .SCALE_LOG2   (4),
        .H_OFFSET     (128),
        .V_OFFSET     (104),
        .V_ACTIVE     (720),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .active_in       (active_in),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .light_color_in  (light_color_in),
        .dark_color_in   (dark_color_in),
        .border_color_in (border_color_in),
        .pixel_in        (pixel_in),
        .pixel_x_out     (pixel_x_out),
        .pixel_y_out     (pixel_y_out),
        .rgb_out         (rgb_out),
        .active_out      (active_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .frame_swap_out  (frame_swap_out)
    );

    typedef struct {
        int         due;
        logic [5:0] px;
        logic [4:0] py;
        bit         swap;
    } s1_t;

    typedef struct {
        int due;
        int cat;
        bit dim;
        bit act;
        bit hs;
        bit vs;
    } s2_t;

    typedef struct {
        int         h;
        int         v;
        bit         act;
        logic [5:0] px;
        logic [4:0] py;
        bit         swap;
        int         cat;
        bit         dim;
    } vec_t;

    s1_t q1[$];
    s2_t q2[$];
    bit  pq[$];
    vec_t tab[14];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int swap_seen = 0;
    logic [23:0] prev_light, prev_dark, prev_border;

    // Chip-8 image held by the video-core model: checkerboard, (0,0) lit.
    function automatic bit img(input int x, input int y);
        return ((x + y) % 2) == 0;
    endfunction

    function automatic logic [23:0] halve(input logic [23:0] c);
        logic [7:0] r, g, b;
        r = c[23:16] / 8'd2;
        g = c[15:8] / 8'd2;
        b = c[7:0] / 8'd2;
        return {r, g, b};
    endfunction

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic check_now();
        s1_t e1;
        s2_t e2;
        logic [23:0] exp_rgb;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e1 = q1.pop_front();
            chk("pixel_x", {18'd0, pixel_x_out}, {18'd0, e1.px});
            chk("pixel_y", {19'd0, pixel_y_out}, {19'd0, e1.py});
            chk("frame_swap", {23'd0, frame_swap_out}, {23'd0, e1.swap});
        end
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            e2 = q2.pop_front();
            case (e2.cat)
                CAT_BORDER: exp_rgb = prev_border;
                CAT_DARK:   exp_rgb = prev_dark;
                CAT_LIT:    exp_rgb = prev_light;
                default:    exp_rgb = 24'h000000;
            endcase
            if (e2.dim) exp_rgb = halve(exp_rgb);
            chk("rgb", rgb_out, exp_rgb);
            chk("active", {23'd0, active_out}, {23'd0, e2.act});
            chk("hsync", {23'd0, hsync_out}, {23'd0, e2.hs});
            chk("vsync", {23'd0, vsync_out}, {23'd0, e2.vs});
        end
    endtask

    // One raster cycle: drive inputs, queue expectations, check due outputs.
    task automatic drive(input int h, input int v, input bit act, input bit hs,
                         input bit vs, input bit rst, input logic [5:0] epx,
                         input logic [4:0] epy, input bit eswap, input int ecat,
                         input bit edim);
        s1_t e1;
        s2_t e2;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        active_in = act;
        hsync_in  = hs;
        vsync_in  = vs;
        rst_in    = rst;
        if (rst) begin
            foreach (q2[i]) begin
                if (q2[i].due > cyc) begin
                    q2[i].cat = CAT_BLACK;
                    q2[i].dim = 1'b0;
                    q2[i].act = 1'b0;
                    q2[i].hs  = 1'b0;
                    q2[i].vs  = 1'b0;
                end
            end
        end
        e1.due  = cyc + 1;
        e1.px   = rst ? 6'd0 : epx;
        e1.py   = rst ? 5'd0 : epy;
        e1.swap = rst ? 1'b0 : eswap;
        q1.push_back(e1);
        e2.due = cyc + 2 + RL;
        e2.cat = rst ? CAT_BLACK : ecat;
        e2.dim = rst ? 1'b0 : edim;
        e2.act = rst ? 1'b0 : act;
        e2.hs  = rst ? 1'b0 : hs;
        e2.vs  = rst ? 1'b0 : vs;
        q2.push_back(e2);
        @(negedge clk_in);
        check_now();
        if (frame_swap_out === 1'b1) swap_seen++;
        pq.push_back(img(int'(pixel_x_out), int'(pixel_y_out)));
        prev_light  = light_color_in;
        prev_dark   = dark_color_in;
        prev_border = border_color_in;
        @(posedge clk_in);
        #1;
        cyc++;
        pixel_in = pq.pop_front();
    endtask

    // Reference model of the window mapping, written from the raster geometry.
    task automatic step_m(input int h, input int v, input bit act, input bit hs,
                          input bit vs, input bit rst);
        bit inw;
        int px, py, cat;
        bit dim, swp;
        inw = (h >= 128) && (h < 128 + 64 * 16) && (v >= 104) && (v < 104 + 32 * 16);
        px  = inw ? (h - 128) / 16 : 0;
        py  = inw ? (v - 104) / 16 : 0;
        if (!act)                  cat = CAT_BLACK;
        else if (!inw)             cat = CAT_BORDER;
        else if (img(px, py))      cat = CAT_LIT;
        else                       cat = CAT_DARK;
        dim = SCAN && act && inw && (((v - 104) % 16) == 15);
        swp = (h == 0) && (v == 720);
        drive(h, v, act, hs, vs, rst, 6'(px), 5'(py), swp, cat, dim);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int hl[12];
        int s0;
        hl = '{0, 100, 127, 128, 143, 144, 600, 1151, 1152, 1279, 1300, 1649};

        // {h, v, active, px, py, swap, colour category, dimmed}
        tab[0]  = '{128,  104, 1'b1, 6'd0,  5'd0,  1'b0, CAT_LIT,    1'b0};
        tab[1]  = '{1151, 104, 1'b1, 6'd63, 5'd0,  1'b0, CAT_DARK,   1'b0};
        tab[2]  = '{1152, 104, 1'b1, 6'd0,  5'd0,  1'b0, CAT_BORDER, 1'b0};
        tab[3]  = '{127,  104, 1'b1, 6'd0,  5'd0,  1'b0, CAT_BORDER, 1'b0};
        tab[4]  = '{128,  615, 1'b1, 6'd0,  5'd31, 1'b0, CAT_DARK,   SCAN};
        tab[5]  = '{128,  616, 1'b1, 6'd0,  5'd0,  1'b0, CAT_BORDER, 1'b0};
        tab[6]  = '{128,  616, 1'b0, 6'd0,  5'd0,  1'b0, CAT_BLACK,  1'b0};
        tab[7]  = '{200,  119, 1'b1, 6'd4,  5'd0,  1'b0, CAT_LIT,    SCAN};
        tab[8]  = '{200,  118, 1'b1, 6'd4,  5'd0,  1'b0, CAT_LIT,    1'b0};
        tab[9]  = '{0,    720, 1'b0, 6'd0,  5'd0,  1'b1, CAT_BLACK,  1'b0};
        tab[10] = '{0,    719, 1'b1, 6'd0,  5'd0,  1'b0, CAT_BORDER, 1'b0};
        tab[11] = '{143,  120, 1'b1, 6'd0,  5'd1,  1'b0, CAT_DARK,   1'b0};
        tab[12] = '{144,  103, 1'b1, 6'd0,  5'd0,  1'b0, CAT_BORDER, 1'b0};
        tab[13] = '{1000, 300, 1'b1, 6'd54, 5'd12, 1'b0, CAT_LIT,    1'b0};

        rst_in = 1'b1; hcount_in = 11'd0; vcount_in = 10'd0;
        active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; pixel_in = 1'b0;
        light_color_in  = 24'hFF80FE;
        dark_color_in   = 24'h204060;
        border_color_in = 24'h123456;
        prev_light = light_color_in; prev_dark = dark_color_in; prev_border = border_color_in;
        for (int i = 0; i < RL - 1; i++) pq.push_back(1'b0);

        @(posedge clk_in);
        #1;
        repeat (3) step_m(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step_m(1300, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed vectors: window edges, bottom row, scanline rows, swap point.
        for (int i = 0; i < 14; i++) begin
            drive(tab[i].h, tab[i].v, tab[i].act, 1'b0, 1'b0, 1'b0,
                  tab[i].px, tab[i].py, tab[i].swap, tab[i].cat, tab[i].dim);
        end
        repeat (RL + 3) step_m(1300, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-line inside the window, then released.
        for (int h = 490; h < 500; h++) step_m(h, 200, 1'b1, 1'b0, 1'b0, 1'b0);
        step_m(500, 200, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int h = 501; h < 513; h++) step_m(h, 200, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random raster positions with live palette changes.
        for (int i = 0; i < 400; i++) begin
            if ((i % 7) == 0) begin
                light_color_in  = 24'($urandom);
                dark_color_in   = 24'($urandom);
                border_color_in = 24'($urandom);
            end
            step_m($urandom_range(1200, 100), $urandom_range(630, 90),
                   ($urandom_range(7, 0) != 0), 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)), 1'b0);
        end
        light_color_in  = 24'hFF80FE;
        dark_color_in   = 24'h204060;
        border_color_in = 24'h123456;

        // Two compressed frames: all rows, a sparse set of columns per row.
        s0 = swap_seen;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < 750; v++) begin
                for (int k = 0; k < 12; k++) begin
                    step_m(hl[k], v, (hl[k] < 1280) && (v < 720), hl[k] == 1300,
                           (v >= 725) && (v < 730), 1'b0);
                end
            end
        end
        repeat (RL + 3) step_m(1300, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("swaps_in_two_frames", 24'(swap_seen - s0), 24'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
